// File: rtl/digital_tube_ctrl_param_if.sv
// rtl/digital_tube_ctrl_param_if.sv - Avalon-MM slave bus bundle for the seven-segment controller
//
// Purpose : groups the word-addressed register bus of digital_tube_ctrl_param.
// Signals : chipselect (active-high select), write_n / read_n (active-low strobes),
//           address (2-bit word address), writedata (32), readdata (32, registered,
//           read latency 1).
// Modports: master drives the strobes, address and write data; slave returns readdata.

interface digital_tube_ctrl_param_if;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect, write_n, read_n, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write_n, read_n, address, writedata,
      output readdata
   );
endinterface

// File: rtl/digital_tube_ctrl_param.sv
// rtl/digital_tube_ctrl_param.sv - parametrised static seven-segment controller with register file
//
// Purpose : drives NUM_DIGITS active-low static digits from a 4-word register file
//           with global/per-digit enable, per-digit blink, PWM brightness and
//           leading-zero blanking.
// Ports   : clk  - system clock
//           rst  - synchronous reset, active-high
//           bus  - register bus (slave modport of digital_tube_ctrl_param_if)
//           hex  - segments, digit i = hex[7i+6:7i], bit0=a..bit6=g, 0 = lit (registered)
// Registers: 0 DATA, 1 CTRL (EN, mask, BRIGHT, LZB), 2 BLINK (mask, HALF), 3 STATUS (phase, ro)

module digital_tube_ctrl_param #(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 25000
) (
   input  logic                        clk,
   input  logic                        rst,
   digital_tube_ctrl_param_if.slave    bus,
   output logic [7*NUM_DIGITS-1:0]     hex
);

   localparam int              DW        = 4 * NUM_DIGITS;
   localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]      PWM_MAX   = 4'd14;
   localparam logic [1:0]      A_DATA    = 2'd0;
   localparam logic [1:0]      A_CTRL    = 2'd1;
   localparam logic [1:0]      A_BLINK   = 2'd2;
   localparam logic [1:0]      A_STATUS  = 2'd3;

   logic [DW-1:0]           data_q, data_d;
   logic                    en_q, en_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [3:0]              bright_q, bright_d;
   logic                    lzb_q, lzb_d;
   logic [NUM_DIGITS-1:0]   bmask_q, bmask_d;
   logic [15:0]             half_q, half_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [3:0]              pwm_q, pwm_d;
   logic [15:0]             bcnt_q, bcnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

   logic                    wr, rd, tick, pwm_on, upper_zero;
   logic [31:0]             rdata;
   logic [NUM_DIGITS-1:0]   lzblank;
   logic                    unused_wdata;

   // Not every writedata bit maps to a register for every NUM_DIGITS.
   assign unused_wdata = ^bus.writedata;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   // Register writes, free-running prescaler and PWM counter.
   always_comb begin
      wr       = bus.chipselect & ~bus.write_n;
      rd       = bus.chipselect & ~bus.read_n;
      tick     = (presc_q == PRESC_MAX);
      presc_d  = tick ? '0 : presc_q + 1'b1;
      pwm_d    = (pwm_q == PWM_MAX) ? 4'd0 : pwm_q + 4'd1;
      pwm_on   = (pwm_q < bright_q);
      data_d   = data_q;
      en_d     = en_q;
      mask_d   = mask_q;
      bright_d = bright_q;
      lzb_d    = lzb_q;
      bmask_d  = bmask_q;
      half_d   = half_q;
      if (wr) begin
         case (bus.address)
            A_DATA:  data_d = bus.writedata[DW-1:0];
            A_CTRL: begin
               en_d     = bus.writedata[0];
               mask_d   = bus.writedata[8 +: NUM_DIGITS];
               bright_d = bus.writedata[19:16];
               lzb_d    = bus.writedata[24];
            end
            A_BLINK: begin
               bmask_d = bus.writedata[NUM_DIGITS-1:0];
               half_d  = bus.writedata[31:16];
            end
            default: ;
         endcase
      end
   end

   // Blink time base: a BLINK write restarts the period and wins over a coincident tick.
   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (wr && bus.address == A_BLINK) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (half_q == 16'd0) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (tick) begin
         if (bcnt_q == half_q - 16'd1) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 16'd1;
         end
      end
   end

   // Readback uses the pre-write register values, so read+write returns old data.
   always_comb begin
      rdata = '0;
      case (bus.address)
         A_DATA:  rdata[DW-1:0] = data_q;
         A_CTRL: begin
            rdata[0]              = en_q;
            rdata[8 +: NUM_DIGITS] = mask_q;
            rdata[19:16]          = bright_q;
            rdata[24]             = lzb_q;
         end
         A_BLINK: begin
            rdata[NUM_DIGITS-1:0] = bmask_q;
            rdata[31:16]          = half_q;
         end
         default: rdata[0] = phase_q;
      endcase
      readdata_d = rd ? rdata : readdata_q;
   end

   // Leading-zero blank scans from the top digit down; digit 0 is always kept.
   always_comb begin
      lzblank    = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (data_q[4*i +: 4] == 4'd0);
         lzblank[i] = lzb_q & upper_zero;
      end
      hex_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_q && mask_q[i] && pwm_on && !(bmask_q[i] && phase_q) && !lzblank[i])
            hex_d[7*i +: 7] = glyph(data_q[4*i +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q     <= '0;
         en_q       <= 1'b1;
         mask_q     <= '1;
         bright_q   <= 4'd15;
         lzb_q      <= 1'b0;
         bmask_q    <= '0;
         half_q     <= '0;
         presc_q    <= '0;
         pwm_q      <= '0;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         readdata_q <= '0;
         hex_q      <= '1;
      end else begin
         data_q     <= data_d;
         en_q       <= en_d;
         mask_q     <= mask_d;
         bright_q   <= bright_d;
         lzb_q      <= lzb_d;
         bmask_q    <= bmask_d;
         half_q     <= half_d;
         presc_q    <= presc_d;
         pwm_q      <= pwm_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
         hex_q      <= hex_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign hex          = hex_q;

endmodule

// File: tb/tb_digital_tube_ctrl_param.sv
// tb/tb_digital_tube_ctrl_param.sv - directed self-checking bench for digital_tube_ctrl_param

module tb_digital_tube_ctrl_param;
   localparam int ND = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [41:0]   hex;
   int            errors = 0;
   int            checks = 0;

   localparam logic [41:0] ALL_OFF  = {42{1'b1}};
   localparam logic [41:0] ALL_ZERO = {6{7'h40}};

   digital_tube_ctrl_param_if bus_if ();

   digital_tube_ctrl_param #(.NUM_DIGITS(ND), .TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave),
      .hex (hex)
   );

   always #5 clk = ~clk;

   function automatic logic [41:0] hx(input logic [6:0] d5, d4, d3, d2, d1, d0);
      return {d5, d4, d3, d2, d1, d0};
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0; bus_if.address = a; bus_if.writedata = d;
      @(negedge clk);
      bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.read_n = 1'b0; bus_if.address = a;
      @(negedge clk);
      bus_if.chipselect = 1'b0; bus_if.read_n = 1'b1;
      d = bus_if.readdata;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1;
      bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.read_n = 1'b1;
      bus_if.address = 2'd0; bus_if.writedata = 32'd0;
      repeat (3) @(negedge clk);
      checks++; if (hex !== ALL_OFF) begin errors++; $display("FAIL reset_hex_blank: got %h expected %h", hex, ALL_OFF); end
      checks++; if (bus_if.readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", bus_if.readdata); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (hex !== ALL_ZERO) begin errors++; $display("FAIL reset_hex_zeros: got %h expected %h", hex, ALL_ZERO); end
      bus_read(2'd1, r);
      checks++; if (r !== 32'h000F3F01) begin errors++; $display("FAIL reset_ctrl: got %h expected 000f3f01", r); end
      bus_read(2'd2, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_blink: got %h expected 0", r); end
   endtask

   task automatic test_data();
      logic [31:0] r;
      logic [41:0] exp;
      exp = hx(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
      bus_write(2'd0, 32'hAB012345);
      checks++; if (hex !== ALL_ZERO) begin errors++; $display("FAIL data_latency_old: got %h expected %h", hex, ALL_ZERO); end
      @(negedge clk);
      checks++; if (hex !== exp) begin errors++; $display("FAIL data_glyphs: got %h expected %h", hex, exp); end
      bus_read(2'd0, r);
      checks++; if (r !== 32'h00012345) begin errors++; $display("FAIL data_readback: got %h expected 00012345", r); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0; bus_if.read_n = 1'b0;
      bus_if.address = 2'd0; bus_if.writedata = 32'h00FEDCBA;
      @(negedge clk);
      bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.read_n = 1'b1;
      checks++; if (bus_if.readdata !== 32'h00012345) begin errors++; $display("FAIL rw_same_cycle_old: got %h expected 00012345", bus_if.readdata); end
      bus_read(2'd0, r);
      checks++; if (r !== 32'h00FEDCBA) begin errors++; $display("FAIL rw_same_cycle_new: got %h expected 00fedcba", r); end
      @(negedge clk);
      bus_write(2'd0, 32'h00000000);
      bus_read(2'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL rw_readholds: got %h expected 0", r); end
      @(negedge clk);
      checks++; if (bus_if.readdata !== 32'd0) begin errors++; $display("FAIL readdata_hold: got %h expected 0", bus_if.readdata); end
   endtask

   task automatic test_lzb();
      logic [31:0] r;
      logic [41:0] exp;
      bus_write(2'd1, 32'h010F3F01);
      bus_write(2'd0, 32'h00000420);
      @(negedge clk);
      exp = hx(7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24, 7'h40);
      checks++; if (hex !== exp) begin errors++; $display("FAIL lzb_0420: got %h expected %h", hex, exp); end
      bus_write(2'd0, 32'h00000100);
      @(negedge clk);
      exp = hx(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40);
      checks++; if (hex !== exp) begin errors++; $display("FAIL lzb_inner_zero: got %h expected %h", hex, exp); end
      bus_write(2'd0, 32'h00000000);
      @(negedge clk);
      exp = hx(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
      checks++; if (hex !== exp) begin errors++; $display("FAIL lzb_all_zero: got %h expected %h", hex, exp); end
      bus_read(2'd1, r);
      checks++; if (r !== 32'h010F3F01) begin errors++; $display("FAIL lzb_ctrl_readback: got %h expected 010f3f01", r); end
   endtask

   task automatic test_brightness();
      int lit0, lit5;
      logic [3:0] br [3] = '{4'd5, 4'd0, 4'd15};
      int expect_lit [3] = '{10, 0, 30};
      for (int k = 0; k < 3; k++) begin
         bus_write(2'd1, {12'h000, br[k], 16'h3F01});
         @(negedge clk);
         lit0 = 0; lit5 = 0;
         for (int c = 0; c < 30; c++) begin
            if (hex[6:0] !== 7'h7F) lit0++;
            if (hex[41:35] !== 7'h7F) lit5++;
            @(negedge clk);
         end
         checks++; if (lit0 != expect_lit[k]) begin errors++; $display("FAIL bright_%0d_digit0: got %0d lit of 30 expected %0d", br[k], lit0, expect_lit[k]); end
         checks++; if (lit5 != expect_lit[k]) begin errors++; $display("FAIL bright_%0d_digit5: got %0d lit of 30 expected %0d", br[k], lit5, expect_lit[k]); end
      end
   endtask

   task automatic test_blink();
      logic [31:0] r;
      int n, run;
      bus_write(2'd1, 32'h000F3F01);
      bus_write(2'd2, 32'h00030001);
      n = 0;
      while (hex[6:0] !== 7'h7F && n < 40) begin @(negedge clk); n++; end
      checks++; if (n >= 40) begin errors++; $display("FAIL blink_start: got no blank within %0d cycles expected blank", n); end
      run = 0;
      while (hex[6:0] === 7'h7F && run < 40) begin @(negedge clk); run++; end
      checks++; if (run != 12) begin errors++; $display("FAIL blink_off_len: got %0d expected 12", run); end
      run = 0;
      while (hex[6:0] === 7'h40 && run < 40) begin @(negedge clk); run++; end
      checks++; if (run != 12) begin errors++; $display("FAIL blink_on_len: got %0d expected 12", run); end
      checks++; if (hex[13:7] !== 7'h40) begin errors++; $display("FAIL blink_other_digit: got %h expected 40", hex[13:7]); end
      bus_read(2'd3, r);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL status_phase1: got %h expected 1", r); end
      bus_write(2'd2, 32'h00030001);
      bus_read(2'd3, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_restart: got %h expected 0", r); end
      checks++; if (hex[6:0] !== 7'h40) begin errors++; $display("FAIL blink_restart_lit: got %h expected 40", hex[6:0]); end
      bus_write(2'd2, 32'h00000001);
      repeat (20) @(negedge clk);
      bus_read(2'd3, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL half0_phase: got %h expected 0", r); end
      checks++; if (hex[6:0] !== 7'h40) begin errors++; $display("FAIL half0_lit: got %h expected 40", hex[6:0]); end
   endtask

   task automatic test_mask_en();
      logic [31:0] r;
      logic [41:0] exp;
      bus_write(2'd2, 32'h00000000);
      bus_write(2'd1, 32'h000F3C01);
      @(negedge clk);
      exp = hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F);
      checks++; if (hex !== exp) begin errors++; $display("FAIL mask_3c: got %h expected %h", hex, exp); end
      bus_write(2'd1, 32'h000F3C00);
      @(negedge clk);
      checks++; if (hex !== ALL_OFF) begin errors++; $display("FAIL en_off: got %h expected %h", hex, ALL_OFF); end
      bus_write(2'd3, 32'hFFFFFFFF);
      bus_read(2'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_wr_data: got %h expected 0", r); end
      bus_read(2'd1, r);
      checks++; if (r !== 32'h000F3C00) begin errors++; $display("FAIL status_wr_ctrl: got %h expected 000f3c00", r); end
      bus_read(2'd2, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_wr_blink: got %h expected 0", r); end
      bus_read(2'd3, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_wr_status: got %h expected 0", r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      bus_write(2'd0, 32'h00123456);
      bus_write(2'd1, 32'h00033F01);
      bus_write(2'd2, 32'h00010003);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (hex !== ALL_OFF) begin errors++; $display("FAIL midreset_blank: got %h expected %h", hex, ALL_OFF); end
      @(negedge clk);
      checks++; if (hex !== ALL_ZERO) begin errors++; $display("FAIL midreset_zeros: got %h expected %h", hex, ALL_ZERO); end
      bus_read(2'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL midreset_data: got %h expected 0", r); end
      bus_read(2'd1, r);
      checks++; if (r !== 32'h000F3F01) begin errors++; $display("FAIL midreset_ctrl: got %h expected 000f3f01", r); end
      bus_read(2'd2, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL midreset_blink: got %h expected 0", r); end
      bus_read(2'd3, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL midreset_status: got %h expected 0", r); end
      checks++; if (hex !== ALL_ZERO) begin errors++; $display("FAIL midreset_full_bright: got %h expected %h", hex, ALL_ZERO); end
   endtask

   initial begin
      test_reset();
      test_data();
      test_back_to_back();
      test_lzb();
      test_brightness();
      test_blink();
      test_mask_en();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
